// File: rtl/eth_axi_wr_master.sv
// AXI4 write initiator: splits a word-stream transfer into INCR bursts bounded by
// MAX_BEATS and 4 KiB pages, with a single burst outstanding at a time.
module eth_axi_wr_master #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] AXI_ID    = '0,
    parameter int              MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [15:0]         cmd_len,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                done,
    output logic                err,
    output logic                busy
);
    localparam int          BYTES = DATA_W / 8;
    localparam int          BSH   = $clog2(BYTES);
    localparam logic [16:0] MAXB  = 17'(MAX_BEATS);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       rem_words;
    logic [8:0]        beats;
    logic [8:0]        cnt;

    logic [ADDR_W-1:0] cmd_addr_al;
    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       next_rem;
    logic [8:0]        cmd_beats;
    logic [8:0]        next_beats;
    logic              unused_bid;

    // Beats that fit: limited by words left, MAX_BEATS and room to the 4 KiB page end.
    function automatic logic [8:0] calc_beats(input logic [11:0] page_off, input logic [15:0] rem);
        logic [12:0] room;
        logic [16:0] b;
        room = (13'h1000 - {1'b0, page_off}) >> BSH;
        b    = {1'b0, rem};
        if (b > MAXB) b = MAXB;
        if (b > {4'b0, room}) b = {4'b0, room};
        return 9'(b);
    endfunction

    assign cmd_addr_al = cmd_addr & ~ADDR_W'(BYTES - 1);
    assign next_addr   = cur_addr + (ADDR_W'(beats) << BSH);
    assign next_rem    = rem_words - {7'b0, beats};
    assign cmd_beats   = calc_beats(cmd_addr_al[11:0], cmd_len);
    assign next_beats  = calc_beats(next_addr[11:0], next_rem);

    assign m_awid    = AXI_ID;
    assign m_awsize  = 3'(BSH);
    assign m_awburst = 2'b01;
    assign m_wdata   = s_data;
    assign m_wstrb   = '1;
    assign m_wvalid  = (state == DATA) && s_valid;
    assign s_ready   = (state == DATA) && m_wready;
    assign m_wlast   = (state == DATA) && (cnt == 9'd1);
    assign busy      = (state != IDLE);
    assign unused_bid = ^m_bid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            cur_addr  <= '0;
            rem_words <= '0;
            beats     <= '0;
            cnt       <= '0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            m_awvalid <= 1'b0;
            m_bready  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        err       <= 1'b0;
                        cur_addr  <= cmd_addr_al;
                        rem_words <= cmd_len;
                        if (cmd_len == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            beats     <= cmd_beats;
                            m_awaddr  <= cmd_addr_al;
                            m_awlen   <= 8'(cmd_beats - 9'd1);
                            m_awvalid <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        cnt       <= beats;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_wvalid && m_wready) begin
                        cnt <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            m_bready <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        if (m_bresp != 2'b00) err <= 1'b1;
                        cur_addr  <= next_addr;
                        rem_words <= next_rem;
                        if (next_rem == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            beats     <= next_beats;
                            m_awaddr  <= next_addr;
                            m_awlen   <= 8'(next_beats - 9'd1);
                            m_awvalid <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                FIN: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/eth_axi_wr_master.md
# eth_axi_wr_master

AXI4 write initiator that moves a word stream into the Ethernet OUTFIFO AXI4 slave (or any AXI4 memory-mapped slave) on behalf of a packet producer. A command gives start address and length in words; the block segments the transfer into INCR bursts that never exceed `MAX_BEATS` and never cross a 4 KiB boundary, issues AW/W, collects B responses and reports completion and error. It sits between a packet source and the OUTFIFO slave port, clocked on the AXI clock domain.

## Interface

- `DATA_W`, 32: AXI data width (bits); stream word width.
- `ADDR_W`, 32: AXI address width.
- `ID_W`, 8: AXI ID width; all bursts use `AXI_ID`.
- `AXI_ID`, 0: constant AWID value.
- `MAX_BEATS`, 16: maximum beats per burst, power of two, 1..256.

- `clk` in 1: clock (AXI clock domain).
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_addr` in ADDR_W: start byte address, word-aligned (low log2(DATA_W/8) bits ignored, driven as 0).
- `cmd_len` in 16: transfer length in words; 0 is legal.
- `s_data` in DATA_W / `s_valid` in 1 / `s_ready` out 1: source word stream.
- `m_awid` out ID_W, `m_awaddr` out ADDR_W, `m_awlen` out 8, `m_awsize` out 3, `m_awburst` out 2, `m_awvalid` out 1, `m_awready` in 1.
- `m_wdata` out DATA_W, `m_wstrb` out DATA_W/8, `m_wlast` out 1, `m_wvalid` out 1, `m_wready` in 1.
- `m_bid` in ID_W, `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1.
- `done` out 1: one-cycle pulse when a command fully completes.
- `err` out 1: sticky; set by any non-OKAY BRESP, cleared on next command acceptance.
- `busy` out 1: high from command acceptance until `done`.

## Operation

- FSM states: IDLE, ADDR, DATA, RESP, FIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch addr/len into `cur_addr`, `rem_words`; clear `err`; if len=0 go FIN, else ADDR.
- Burst size computed in ADDR: `beats = min(rem_words, MAX_BEATS, (4096 - cur_addr[11:0]) / (DATA_W/8))`. `m_awlen = beats-1`, `m_awsize = log2(DATA_W/8)`, `m_awburst = 2'b01`, `m_awid = AXI_ID`.
- ADDR: `m_awvalid`=1, fields stable until `m_awready`; then DATA with beat counter = beats.
- DATA: `m_wvalid = s_valid`, `s_ready = m_wready`, `m_wdata = s_data`, `m_wstrb` all ones; `m_wlast`=1 when beat counter = 1. Each W handshake decrements counter; on last beat go RESP.
- RESP: `m_bready`=1. On `m_bvalid`: if `m_bresp != 2'b00` set `err`. `cur_addr += beats*DATA_W/8`, `rem_words -= beats`; if `rem_words` now 0 go FIN else ADDR.
- FIN: `done`=1 for one cycle, go IDLE.
- One burst outstanding at a time; W never precedes its AW handshake.
- `m_bid` is not checked. Error does not abort; the full length is always written.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing

- Reset values: `cmd_ready`=0 during reset then 1 in IDLE, all `*valid`, `m_wlast`, `m_bready`, `s_ready`, `done`, `busy`, `err` = 0; `m_awaddr`, `m_awlen` = 0.
- Command accepted cycle N → `m_awvalid` at N+1 (single-cycle ADDR entry; burst size from registered state).
- AW handshake at cycle A → first W beat may complete at A+1.
- Last W beat at W → `m_bready` at W+1; B accepted at B → next `m_awvalid` at B+1, or `done` at B+1.
- len=0: `done` at N+1, no AXI traffic.
- `cmd_ready`=0 whenever state ≠ IDLE; `busy` = state ≠ IDLE.
- AXI valid signals never deassert before handshake; payload held stable while valid and not ready.
- Source stalls (`s_valid`=0) or slave stalls (`m_wready`=0) freeze the beat counter; no bubbles inserted otherwise (one beat/cycle sustained).
- Async reset mid-burst: all outputs return to reset values immediately; no completion reported; in-flight AXI transaction is abandoned.

## Test plan

- cmd_addr=0x1000, len=4, always-ready slave → one AW (awaddr 0x1000, awlen 3, awsize 2, awburst 1), 4 W beats, wlast on 4th, `done` one cycle after B, `err`=0.
- cmd_addr=0x0, len=40, MAX_BEATS=16 → bursts awlen 15,15,7 at 0x0, 0x40, 0x80; data order preserved; one `done`.
- cmd_addr=0x0FF8, len=6 → bursts awlen 1 at 0x0FF8 and awlen 3 at 0x1000 (no 4 KiB crossing).
- len=8, second-beat bresp=SLVERR on burst of 2 with MAX_BEATS=2 → all 8 words written, `err`=1 after done; next command clears `err`.
- Random `s_valid`/`m_wready`/`m_awready`/`m_bvalid` stalls, len=100 → data integrity, AXI stability rules hold, exactly 100 W beats.
- len=0 → `done` at N+1, no awvalid; reset asserted mid-DATA → all valids 0 same cycle, IDLE after release, next command executes normally.
